// File: rtl/and3_sweep_driver_pkg.sv
// Shared definitions for the AND-gate sweep driver: FSM encoding and hold-timer width.
package and3_sweep_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wide enough to count up to a hold of 16 cycles.
    localparam int HOLD_W = 5;

endpackage

// File: rtl/and3_sweep_driver_hold_timer.sv
// Per-vector hold timer: counts cycles while enabled and flags the last held cycle.
module hold_timer
    import and3_sweep_driver_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [HOLD_W-1:0] TERM = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    assign expire = enable && (count_q == TERM);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = expire ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/andgate2.sv
// Three-input combinational AND gate exercised by the sweep driver.
module andgate2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s
);

    assign s = a & b & c;

endmodule

// File: rtl/and3_sweep_driver.sv
// Drives every input combination onto the AND gate, captures the observed truth
// table and records the first vector whose response differs from an ideal AND.
//
// state   | meaning
// IDLE    | waiting for start, vec parked at 0
// RUN     | sweeping vectors, sampling s_in on the last held cycle
// DONE    | sweep complete, outputs frozen until start or reset
module and3_sweep_driver
    import and3_sweep_driver_pkg::*;
#(
    parameter int N           = 3,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_in,
    output logic [N-1:0]      vec,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   result,
    output logic              mismatch,
    output logic [N-1:0]      err_index
);

    localparam int          NV   = 2**N;
    localparam logic [N-1:0] LAST = '1;

    state_t          state_q, state_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [NV-1:0]   result_q, result_d;
    logic            mismatch_q, mismatch_d;
    logic [N-1:0]    err_q, err_d;

    logic            timer_clear;
    logic            timer_en;
    logic            expire;
    logic            expected;

    // The timer is held cleared outside RUN so the first vector gets a full hold.
    assign timer_clear = (state_q != ST_RUN);
    assign timer_en    = (state_q == ST_RUN);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expire  (expire)
    );

    assign expected = (vec_q == LAST);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        result_d   = result_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    vec_d      = '0;
                    result_d   = '0;
                    mismatch_d = 1'b0;
                    err_d      = '0;
                end
            end
            ST_RUN: begin
                if (expire) begin
                    result_d[vec_q] = s_in;
                    if ((s_in != expected) && !mismatch_q) begin
                        mismatch_d = 1'b1;
                        err_d      = vec_q;
                    end
                    if (vec_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            result_q   <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            result_q   <= result_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign mismatch  = mismatch_q;
    assign err_index = err_q;

endmodule
